// File: rtl/nes_ctrl_reader.sv
// NES pad polling master: latch pulse, shift clock/strobe, MSB-first capture into an active-high byte.
// Optional NES_READER_DEBOUNCE_EN: Buttons update only when two consecutive scans agree.
module nes_ctrl_reader #(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833333
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Poll_Req,
  input  logic       Serial_In,
  output logic       Latch,
  output logic       Shift,
  output logic       Shift_Strobe,
  output logic [7:0] Buttons,
  output logic       Valid,
  output logic       Busy
);

  localparam int MAXC = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = (POLL_CYCLES < 2) ? 1 : $clog2(POLL_CYCLES);
  localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST  = (POLL_CYCLES == 0) ? '0 : PW'(POLL_CYCLES - 1);
  localparam bit            AUTO_POLL  = (POLL_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SAMPLE, S_CLK_HI, S_CLK_LO, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    raw_q, raw_d;
  logic [7:0]    buttons_d;
`ifdef NES_READER_DEBOUNCE_EN
  logic [7:0]    prev_q, prev_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = '0;
    idx_d     = idx_q;
    raw_d     = raw_q;
    buttons_d = Buttons;
`ifdef NES_READER_DEBOUNCE_EN
    prev_d    = prev_q;
`endif
    case (state_q)
      S_IDLE: begin
        timer_d = timer_q + PW'(1);
        if (Poll_Req || (AUTO_POLL && (timer_q == POLL_LAST))) begin
          timer_d = '0;
          cnt_d   = LATCH_LOAD;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_SAMPLE: begin
        raw_d[3'd7 - idx_q] = Serial_In;
        cnt_d   = HALF_LOAD;
        state_d = S_CLK_HI;
      end
      S_CLK_HI: begin
        if (cnt_q == '0) begin
          cnt_d   = HALF_LOAD;
          state_d = S_CLK_LO;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CLK_LO: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (idx_q == 3'd7) begin
          // Buttons load on the edge into DONE so they are valid alongside Valid.
          state_d = S_DONE;
`ifdef NES_READER_DEBOUNCE_EN
          if (raw_q == prev_q) buttons_d = ~raw_q;
          prev_d = raw_q;
`else
          buttons_d = ~raw_q;
`endif
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_SAMPLE;
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      idx_q        <= '0;
      raw_q        <= 8'hFF;
      Buttons      <= 8'h00;
      Latch        <= 1'b0;
      Shift        <= 1'b0;
      Shift_Strobe <= 1'b0;
      Valid        <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      raw_q        <= raw_d;
      Buttons      <= buttons_d;
      Latch        <= (state_d == S_LATCH);
      Shift        <= (state_d == S_CLK_HI);
      Shift_Strobe <= (state_d == S_CLK_HI) && (state_q != S_CLK_HI);
      Valid        <= (state_d == S_DONE);
      Busy         <= (state_d != S_IDLE);
    end
  end

`ifdef NES_READER_DEBOUNCE_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) prev_q <= 8'hFF;
    else          prev_q <= prev_d;
  end
`endif

endmodule

// File: doc/nes_ctrl_reader.md
Name: nes_ctrl_reader

Overview:
- Polling master for the 8-bit parallel-load/serial-out controller shift register, on-chip or external NES pad.
- Generates the latch pulse and the shift clock, samples the serial data bit (MSB first) and assembles an active-high button byte.
- The button byte feeds the game logic.
- Sits directly downstream of the controller register:
  - Latch drives its Load.
  - Shift_Strobe drives its Shift_Enable.
  - Its Data_Out drives Serial_In.

Parameters:
- LATCH_CYCLES, 600: clock cycles Latch is held high (12 us at 50 MHz); must be >= 1.
- HALF_CYCLES, 300: cycles per high and per low phase of Shift; must be >= 1.
- POLL_CYCLES, 833333: IDLE cycles between automatic scans (60 Hz); 0 disables auto-poll.

Ports:
- Clk  input  1  system clock
- Reset_n  input  1  asynchronous, active-low reset
- Poll_Req  input  1  request an immediate scan; sampled in IDLE only
- Serial_In  input  1  serial data from the controller; 1 = released
- Latch  output  1  controller latch/load level
- Shift  output  1  controller shift clock level, for the external pin
- Shift_Strobe  output  1  single-cycle pulse on the first cycle of each Shift high phase, for on-chip shift registers
- Buttons  output  8  last captured button state, active-high; bit 7 = first bit shifted out
- Valid  output  1  one-cycle pulse when a scan completes
- Busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset (async, Reset_n low) forces:
  - state IDLE
  - Latch=0, Shift=0, Shift_Strobe=0, Valid=0, Busy=0
  - Buttons=8'h00
  - poll timer=0, bit index=0, raw capture=8'hFF
- Reset asserted mid-scan aborts the scan with no Valid pulse; after release the block waits in IDLE for a trigger.
- States: IDLE, LATCH, SAMPLE, CLK_HI, CLK_LO, DONE.
- IDLE:
  - Poll timer increments each cycle.
  - Trigger = Poll_Req, or (POLL_CYCLES != 0 and timer == POLL_CYCLES-1).
  - On trigger: timer cleared, go to LATCH.
  - Poll_Req and a timer trigger in the same cycle start one scan.
  - Poll_Req outside IDLE is ignored; it is not queued.
- LATCH: Latch=1 for exactly LATCH_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle, Latch=0, Shift=0):
  - raw[7-idx] <= Serial_In.
  - Go to CLK_HI.
  - Serial_In is ignored in every other state.
- CLK_HI:
  - Shift=1 for HALF_CYCLES cycles.
  - Shift_Strobe=1 on the first of those cycles only.
  - Go to CLK_LO.
- CLK_LO:
  - Shift=0 for HALF_CYCLES cycles.
  - If idx==7 go to DONE; otherwise idx++ and go to SAMPLE.
- Pulse count: exactly 8 shift pulses and 8 strobes per scan. The 8th pulse follows the last sample, matching NES timing.
- DONE (1 cycle):
  - Buttons <= ~raw.
  - Valid=1.
  - idx=0.
  - Go to IDLE.
- Timing (cycle 0 = first cycle Latch is high):
  - Bit i sampled at cycle LATCH_CYCLES + i*(2*HALF_CYCLES+1).
  - Valid high at cycle LATCH_CYCLES + 8*(2*HALF_CYCLES+1).
  - Buttons are valid from the same cycle as Valid.
- Buttons holds its value between scans; it never changes except in DONE or on reset.
- Back-to-back scans: after DONE the timer restarts from 0. With Poll_Req held high, the next Latch rises on the second cycle after Valid.

Optional Feature:
- Macro: NES_READER_DEBOUNCE_EN.
- When defined:
  - The previous scan's raw value is stored; its reset value is 8'hFF.
  - In DONE, Buttons <= ~raw only if raw equals the stored value; otherwise Buttons holds.
  - The stored value is then updated to raw.
  - Valid still pulses on every scan.
  - A press is therefore reported only after two identical consecutive scans.
- When undefined: Buttons updates on every scan, and no extra storage is inferred.

Test Plan:
- Parameters LATCH_CYCLES=4, HALF_CYCLES=2, POLL_CYCLES=0. Poll_Req pulse; controller register loaded with 8'b0111_1110 while Latch is high.
  -> Latch high 4 cycles; 8 Shift pulses each 2 cycles high / 2 low; 8 single-cycle strobes; Valid at cycle 44; Buttons=8'h81; Busy low after DONE.
- Controller loaded with 8'hFF.
  -> Buttons=8'h00 and Valid pulses.
- Controller loaded with 8'h00.
  -> Buttons=8'hFF.
- POLL_CYCLES=100, Poll_Req tied low.
  -> Latch rises every 100+45 cycles; Poll_Req pulsed during CLK_HI produces no second scan.
- Reset_n low at cycle 20 of a scan.
  -> all outputs return to reset values in the same cycle with no clock edge; no Valid pulse; Buttons=8'h00; a new Poll_Req completes a normal scan.
- With NES_READER_DEBOUNCE_EN: scans returning raw 8'h7F, then 8'hFF, then 8'h7F, then 8'h7F.
  -> Buttons = 8'h00, 8'h00, 8'h00, 8'h80; Valid pulses on all four scans.
